// File: rtl/payment_change_unit.sv
// Vending-machine payment datapath: accumulates cash or credit against the selected price,
// runs the vend/cancel handshakes, splits change into coin counts and provides a latch clock gate.
module payment_change_unit #(
    parameter int NUM_ITEMS = 8,
    parameter int PRICE_W   = 8
) (
    input  logic                         clk2,
    input  logic                         rst,
    input  logic                         clk_en,
    output logic                         gclk,
    input  logic [1:0]                   state,
    input  logic                         cancelled,
    input  logic                         payment_method,
    input  logic [NUM_ITEMS*PRICE_W-1:0] cost,
    input  logic [3:0]                   cur_index,
    input  logic [8:0]                   cred_balance,
    input  logic                         dollar,
    input  logic                         quarter,
    input  logic                         dime,
    input  logic                         nickel,
    input  logic                         reduce_inventory_done,
    input  logic                         change_state_done,
    output logic                         reduce_inventory,
    output logic [8:0]                   change,
    output logic                         cancelled_done,
    output logic                         change_state,
    output logic [4:0]                   quarter_o,
    output logic [4:0]                   dime_o,
    output logic [4:0]                   nickel_o
);

    typedef enum logic [1:0] {
        ST_SELECT = 2'b00,
        ST_PAY    = 2'b01,
        ST_VEND   = 2'b10,
        ST_CANCEL = 2'b11
    } machine_state_t;

    typedef enum logic [1:0] {
        V_IDLE,
        V_REQ,
        V_HOLD
    } vend_state_t;

    localparam logic [8:0] BAL_MAX = 9'd511;

    logic [3:0]         idx;
    logic [PRICE_W-1:0] price_slot;
    logic [8:0]         price;
    logic [8:0]         balance;
    logic [8:0]         coin_val;
    logic [8:0]         pay_in;
    logic [9:0]         raw_sum;
    logic [8:0]         bal_sum;
    logic [8:0]         rem25;
    logic               cash;
    logic               in_pay;
    logic               in_vend;
    logic               cancel_req;
    logic               cancel_prev;
    logic               cancel_edge;
    logic               vend_load;
    logic               pay_ok;
    logic               en_latch;
    vend_state_t        vstate;
    vend_state_t        vnext;

    // Only the low index bits select a slot; the mask keeps the upper bit harmless.
    assign idx        = cur_index & 4'(NUM_ITEMS - 1);
    assign price_slot = PRICE_W'(cost >> (idx * PRICE_W));
    assign price      = 9'(price_slot);

    always_comb begin
        coin_val = '0;
        if (dollar)  coin_val = coin_val + 9'd100;
        if (quarter) coin_val = coin_val + 9'd25;
        if (dime)    coin_val = coin_val + 9'd10;
        if (nickel)  coin_val = coin_val + 9'd5;
    end

    assign cash    = !payment_method;
    assign pay_in  = cash ? coin_val : '0;
    assign raw_sum = {1'b0, balance} + {1'b0, pay_in};
    assign bal_sum = raw_sum[9] ? BAL_MAX : raw_sum[8:0];

    assign in_pay      = (state == ST_PAY);
    assign in_vend     = (state == ST_VEND);
    assign cancel_req  = (cancelled || state == ST_CANCEL) && !in_vend;
    assign cancel_edge = cancel_req && !cancel_prev;
    assign vend_load   = (vstate == V_REQ) && reduce_inventory_done;
    assign pay_ok      = cash ? (balance >= price) : (cred_balance >= price);

    always_ff @(posedge clk2) begin
        if (rst) begin
            balance        <= '0;
            change         <= '0;
            change_state   <= 1'b0;
            cancelled_done <= 1'b0;
            cancel_prev    <= 1'b0;
        end else begin
            cancel_prev    <= cancel_req;
            cancelled_done <= cancel_edge;
            if (cancel_req) begin
                // Refund loads once per cancel; a held cancel only keeps the balance cleared.
                balance      <= '0;
                change_state <= 1'b0;
                if (cancel_edge) change <= bal_sum;
            end else if (vend_load) begin
                balance      <= '0;
                change       <= (cash && balance >= price) ? (balance - price) : '0;
                change_state <= 1'b0;
            end else begin
                if (in_pay && cash && coin_val != '0) begin
                    balance <= bal_sum;
                    // An empty balance means this is the transaction's first coin.
                    if (balance == '0) change <= '0;
                end
                if (!in_pay)
                    change_state <= 1'b0;
                else if (change_state && change_state_done)
                    change_state <= 1'b0;
                else if (pay_ok)
                    change_state <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk2) begin
        if (rst) vstate <= V_IDLE;
        else     vstate <= vnext;
    end

    always_comb begin
        vnext            = vstate;
        reduce_inventory = 1'b0;
        unique case (vstate)
            V_IDLE: if (in_vend) vnext = V_REQ;
            V_REQ: begin
                reduce_inventory = 1'b1;
                if (reduce_inventory_done) vnext = V_HOLD;
            end
            // Wait for the machine to leave VEND so one vend never decrements twice.
            V_HOLD:  if (!in_vend) vnext = V_IDLE;
            default: vnext = V_IDLE;
        endcase
    end

    assign rem25     = change % 9'd25;
    assign quarter_o = rst ? '0 : 5'(change / 9'd25);
    assign dime_o    = rst ? '0 : 5'(rem25 / 9'd10);
    assign nickel_o  = rst ? '0 : 5'((rem25 % 9'd10) / 9'd5);

    // Enable is only transparent while clk2 is low, so gclk high phases are never cut short.
    always_latch begin
        if (!clk2) en_latch = clk_en;
    end

    assign gclk = clk2 & en_latch;

endmodule

// File: tb/tb_payment_change_unit.sv
// Self-checking bench for payment_change_unit: directed scenarios plus randomized
// transactions scored against a transaction-level payment model.
`timescale 1ns/1ps
module tb_payment_change_unit;

    localparam int NUM_ITEMS = 8;
    localparam int PRICE_W   = 8;

    typedef enum logic [1:0] {S_SELECT = 2'b00, S_PAY = 2'b01, S_VEND = 2'b10, S_CANCEL = 2'b11} mstate_t;

    logic        clk2 = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        gclk;
    logic [1:0]  state;
    logic        cancelled;
    logic        payment_method;
    logic [63:0] cost;
    logic [3:0]  cur_index;
    logic [8:0]  cred_balance;
    logic        dollar, quarter, dime, nickel;
    logic        reduce_inventory_done;
    logic        change_state_done;
    logic        reduce_inventory;
    logic [8:0]  change;
    logic        cancelled_done;
    logic        change_state;
    logic [4:0]  quarter_o, dime_o, nickel_o;

    int checks = 0;
    int failures = 0;
    int model_change = 0;
    int gclk_rises = 0;

    payment_change_unit #(.NUM_ITEMS(NUM_ITEMS), .PRICE_W(PRICE_W)) dut (
        .clk2(clk2), .rst(rst), .clk_en(clk_en), .gclk(gclk), .state(state),
        .cancelled(cancelled), .payment_method(payment_method), .cost(cost),
        .cur_index(cur_index), .cred_balance(cred_balance), .dollar(dollar),
        .quarter(quarter), .dime(dime), .nickel(nickel),
        .reduce_inventory_done(reduce_inventory_done), .change_state_done(change_state_done),
        .reduce_inventory(reduce_inventory), .change(change), .cancelled_done(cancelled_done),
        .change_state(change_state), .quarter_o(quarter_o), .dime_o(dime_o), .nickel_o(nickel_o)
    );

    always #5 clk2 = ~clk2;
    always @(posedge gclk) gclk_rises <= gclk_rises + 1;

    // Greedy coin split by repeated subtraction; returns {quarters, dimes, nickels}.
    function automatic logic [14:0] qdn(input int cents);
        int c = cents;
        int q = 0;
        int d = 0;
        while (c >= 25) begin c -= 25; q++; end
        while (c >= 10) begin c -= 10; d++; end
        return {q[4:0], d[4:0], (c >= 5) ? 5'd1 : 5'd0};
    endfunction

    function automatic int cents_of(input bit d, input bit q, input bit di, input bit n);
        return (d ? 100 : 0) + (q ? 25 : 0) + (di ? 10 : 0) + (n ? 5 : 0);
    endfunction

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic coins(input bit d, input bit q, input bit di, input bit n);
        dollar = d; quarter = q; dime = di; nickel = n;
    endtask

    task automatic set_price(input int idx, input int p);
        cost[idx*PRICE_W +: PRICE_W] = p[PRICE_W-1:0];
        cur_index = idx[3:0];
    endtask

    // Drives change_state ack, VEND, and the inventory ack with bounded waits.
    task automatic vend_handshake(output bit cs_seen, output bit ri_seen, output bit ri_cleared);
        cs_seen = 1'b0;
        ri_seen = 1'b0;
        for (int i = 0; i < 8 && !cs_seen; i++) begin
            if (change_state === 1'b1) cs_seen = 1'b1;
            else tick();
        end
        change_state_done = 1'b1;
        tick();
        change_state_done = 1'b0;
        state = S_VEND;
        for (int i = 0; i < 8 && !ri_seen; i++) begin
            tick();
            if (reduce_inventory === 1'b1) ri_seen = 1'b1;
        end
        reduce_inventory_done = 1'b1;
        tick();
        reduce_inventory_done = 1'b0;
        ri_cleared = (reduce_inventory === 1'b0);
        state = S_SELECT;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (change !== 9'd0) begin failures++; $display("FAIL reset_change: got %0d expected 0", change); end
        checks++; if (change_state !== 1'b0) begin failures++; $display("FAIL reset_change_state: got %b expected 0", change_state); end
        checks++; if (reduce_inventory !== 1'b0) begin failures++; $display("FAIL reset_reduce_inventory: got %b expected 0", reduce_inventory); end
        checks++; if (cancelled_done !== 1'b0) begin failures++; $display("FAIL reset_cancelled_done: got %b expected 0", cancelled_done); end
        checks++; if ({quarter_o, dime_o, nickel_o} !== 15'd0) begin failures++; $display("FAIL reset_coins: got %0d/%0d/%0d expected 0/0/0", quarter_o, dime_o, nickel_o); end
        rst = 1'b0;
        tick();
        model_change = 0;
    endtask

    task automatic test_cash_exact();
        bit cs, ri, ric;
        payment_method = 1'b0;
        set_price(2, 75);
        state = S_PAY;
        for (int i = 0; i < 3; i++) begin coins(0, 1, 0, 0); tick(); end
        coins(0, 0, 0, 0);
        tick();
        checks++; if (change_state !== 1'b1) begin failures++; $display("FAIL exact_change_state: got %b expected 1", change_state); end
        vend_handshake(cs, ri, ric);
        checks++; if (ri !== 1'b1) begin failures++; $display("FAIL exact_reduce_inventory: got %b expected 1", ri); end
        checks++; if (ric !== 1'b1) begin failures++; $display("FAIL exact_ri_release: got %b expected 1", ric); end
        checks++; if (change !== 9'd0) begin failures++; $display("FAIL exact_change: got %0d expected 0", change); end
        checks++; if ({quarter_o, dime_o, nickel_o} !== 15'd0) begin failures++; $display("FAIL exact_coins: got %0d/%0d/%0d expected 0/0/0", quarter_o, dime_o, nickel_o); end
        model_change = 0;
    endtask

    task automatic test_overpay();
        bit cs, ri, ric;
        set_price(5, 65);
        state = S_PAY;
        coins(1, 0, 0, 0); tick(); coins(0, 0, 0, 0);
        vend_handshake(cs, ri, ric);
        checks++; if (cs !== 1'b1) begin failures++; $display("FAIL overpay_change_state: got %b expected 1", cs); end
        checks++; if (change !== 9'd35) begin failures++; $display("FAIL overpay_change: got %0d expected 35", change); end
        checks++; if ({quarter_o, dime_o, nickel_o} !== {5'd1, 5'd1, 5'd0}) begin failures++; $display("FAIL overpay_coins: got %0d/%0d/%0d expected 1/1/0", quarter_o, dime_o, nickel_o); end
        model_change = 35;
    endtask

    task automatic test_cancel();
        int pulses;
        set_price(1, 200);
        state = S_PAY;
        coins(0, 0, 1, 1); tick(); coins(0, 0, 0, 0);
        cancelled = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin tick(); pulses += int'(cancelled_done); end
        cancelled = 1'b0; state = S_SELECT; tick();
        checks++; if (pulses != 1) begin failures++; $display("FAIL cancel_pulse_count: got %0d expected 1", pulses); end
        checks++; if (change !== 9'd15) begin failures++; $display("FAIL cancel_change: got %0d expected 15", change); end
        checks++; if ({quarter_o, dime_o, nickel_o} !== {5'd0, 5'd1, 5'd1}) begin failures++; $display("FAIL cancel_coins: got %0d/%0d/%0d expected 0/1/1", quarter_o, dime_o, nickel_o); end
        // Second cancel with no coins shows the balance was emptied.
        state = S_PAY; tick();
        cancelled = 1'b1; tick();
        checks++; if (cancelled_done !== 1'b1) begin failures++; $display("FAIL cancel_repulse: got %b expected 1", cancelled_done); end
        checks++; if (change !== 9'd0) begin failures++; $display("FAIL cancel_balance_cleared: got %0d expected 0", change); end
        cancelled = 1'b0; state = S_SELECT; tick();
        // Cancel during VEND must be ignored.
        set_price(1, 20);
        state = S_PAY;
        coins(0, 1, 0, 0); tick(); coins(0, 0, 0, 0);
        state = S_VEND; tick();
        cancelled = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin tick(); pulses += int'(cancelled_done); end
        checks++; if (reduce_inventory !== 1'b1) begin failures++; $display("FAIL vend_cancel_ri: got %b expected 1", reduce_inventory); end
        cancelled = 1'b0;
        reduce_inventory_done = 1'b1; tick(); reduce_inventory_done = 1'b0;
        state = S_SELECT; tick();
        checks++; if (pulses != 0) begin failures++; $display("FAIL vend_cancel_pulse: got %0d expected 0", pulses); end
        checks++; if (change !== 9'd5) begin failures++; $display("FAIL vend_cancel_change: got %0d expected 5", change); end
        checks++; if ({quarter_o, dime_o, nickel_o} !== {5'd0, 5'd0, 5'd1}) begin failures++; $display("FAIL vend_cancel_coins: got %0d/%0d/%0d expected 0/0/1", quarter_o, dime_o, nickel_o); end
        model_change = 5;
    endtask

    task automatic test_credit();
        bit cs, ri, ric;
        int cs_high;
        payment_method = 1'b1;
        set_price(4, 120);
        cred_balance = 9'd100;
        state = S_PAY;
        cs_high = 0;
        for (int i = 0; i < 6; i++) begin
            coins($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 1);
            tick();
            cs_high += int'(change_state);
        end
        coins(0, 0, 0, 0); tick();
        checks++; if (cs_high != 0 || change_state !== 1'b0) begin failures++; $display("FAIL credit_short: got %0d high cycles expected 0", cs_high); end
        checks++; if (change !== 9'(model_change)) begin failures++; $display("FAIL credit_coins_keep_change: got %0d expected %0d", change, model_change); end
        coins(1, 1, 1, 1); cancelled = 1'b1; tick();
        coins(0, 0, 0, 0);
        checks++; if (cancelled_done !== 1'b1) begin failures++; $display("FAIL credit_cancel_pulse: got %b expected 1", cancelled_done); end
        checks++; if (change !== 9'd0) begin failures++; $display("FAIL credit_cancel_change: got %0d expected 0", change); end
        cancelled = 1'b0; state = S_SELECT; tick();
        cred_balance = 9'd150;
        state = S_PAY; tick();
        vend_handshake(cs, ri, ric);
        checks++; if (cs !== 1'b1) begin failures++; $display("FAIL credit_change_state: got %b expected 1", cs); end
        checks++; if (change !== 9'd0) begin failures++; $display("FAIL credit_vend_change: got %0d expected 0", change); end
        payment_method = 1'b0;
        model_change = 0;
    endtask

    task automatic test_saturation();
        bit cs, ri, ric;
        set_price(7, 255);
        state = S_PAY;
        for (int i = 0; i < 6; i++) begin coins(1, 0, 0, 0); tick(); end
        coins(0, 1, 0, 0); cancelled = 1'b1; tick();
        coins(0, 0, 0, 0); cancelled = 1'b0; state = S_SELECT; tick();
        checks++; if (change !== 9'd511) begin failures++; $display("FAIL sat_change: got %0d expected 511", change); end
        checks++; if ({quarter_o, dime_o, nickel_o} !== {5'd20, 5'd1, 5'd0}) begin failures++; $display("FAIL sat_coins: got %0d/%0d/%0d expected 20/1/0", quarter_o, dime_o, nickel_o); end
        set_price(3, 63);
        state = S_PAY;
        coins(1, 0, 0, 0); tick(); coins(0, 0, 0, 0);
        vend_handshake(cs, ri, ric);
        checks++; if (change !== 9'd37) begin failures++; $display("FAIL drop_change: got %0d expected 37", change); end
        checks++; if ({quarter_o, dime_o, nickel_o} !== {5'd1, 5'd1, 5'd0}) begin failures++; $display("FAIL drop_coins: got %0d/%0d/%0d expected 1/1/0", quarter_o, dime_o, nickel_o); end
        model_change = 37;
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int idx = $urandom_range(0, 7);
            int price = $urandom_range(0, 255);
            bit credit = 1'($urandom_range(0, 1));
            int cred = $urandom_range(0, 511);
            int ncyc = $urandom_range(1, 8);
            int bal = 0;
            int expc;
            bit first_seen = 1'b0;
            bit ok, cs, ri, ric;
            logic [14:0] e;
            cost = {$urandom, $urandom};
            set_price(idx, price);
            cur_index[3] = 1'($urandom_range(0, 1));
            payment_method = credit;
            cred_balance = 9'(cred);
            state = S_PAY;
            for (int c = 0; c < ncyc; c++) begin
                bit d = ($urandom_range(0, 3) == 0), q = ($urandom_range(0, 2) == 0);
                bit di = ($urandom_range(0, 2) == 0), n = ($urandom_range(0, 2) == 0);
                int cv = cents_of(d, q, di, n);
                coins(d, q, di, n);
                tick();
                if (!credit) begin
                    bal = (bal + cv > 511) ? 511 : bal + cv;
                    if (cv != 0 && !first_seen) begin first_seen = 1'b1; model_change = 0; end
                end
                checks++; if (change !== 9'(model_change)) begin failures++; $display("FAIL rand_change_hold[%0d]: got %0d expected %0d", t, change, model_change); end
            end
            coins(0, 0, 0, 0);
            tick();
            ok = credit ? (cred >= price) : (bal >= price);
            checks++; if (change_state !== ok) begin failures++; $display("FAIL rand_change_state[%0d]: got %b expected %b", t, change_state, ok); end
            if (!ok || $urandom_range(0, 3) == 0) begin
                bit d = 1'($urandom_range(0, 1)), q = 1'($urandom_range(0, 1));
                int cv = cents_of(d, q, 0, 1);
                coins(d, q, 0, 1);
                if ($urandom_range(0, 1) == 1) state = S_CANCEL; else cancelled = 1'b1;
                tick();
                coins(0, 0, 0, 0);
                expc = credit ? bal : ((bal + cv > 511) ? 511 : bal + cv);
                checks++; if (cancelled_done !== 1'b1) begin failures++; $display("FAIL rand_cancel_pulse[%0d]: got %b expected 1", t, cancelled_done); end
                checks++; if (change !== 9'(expc)) begin failures++; $display("FAIL rand_cancel_change[%0d]: got %0d expected %0d", t, change, expc); end
                cancelled = 1'b0; state = S_SELECT; tick();
                checks++; if (cancelled_done !== 1'b0) begin failures++; $display("FAIL rand_cancel_single[%0d]: got %b expected 0", t, cancelled_done); end
            end else begin
                vend_handshake(cs, ri, ric);
                expc = credit ? 0 : bal - price;
                checks++; if ({cs, ri, ric} !== 3'b111) begin failures++; $display("FAIL rand_vend_handshake[%0d]: got %b%b%b expected 111", t, cs, ri, ric); end
                checks++; if (change !== 9'(expc)) begin failures++; $display("FAIL rand_vend_change[%0d]: got %0d expected %0d", t, change, expc); end
            end
            model_change = expc;
            e = qdn(expc);
            checks++; if ({quarter_o, dime_o, nickel_o} !== e) begin failures++; $display("FAIL rand_coins[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", t, quarter_o, dime_o, nickel_o, e[14:10], e[9:5], e[4:0]); end
        end
        payment_method = 1'b0;
    endtask

    task automatic test_clock_gate();
        bit en_cur;
        int rises0, exp_rises;
        clk_en = 1'b1;
        tick(); tick();
        checks++; if (gclk !== 1'b1) begin failures++; $display("FAIL cg_on: got %b expected 1", gclk); end
        #1 clk_en = 1'b0;
        #2;
        checks++; if (gclk !== 1'b1) begin failures++; $display("FAIL cg_no_truncate: got %b expected 1", gclk); end
        @(negedge clk2); #1;
        checks++; if (gclk !== 1'b0) begin failures++; $display("FAIL cg_low_phase: got %b expected 0", gclk); end
        tick();
        checks++; if (gclk !== 1'b0) begin failures++; $display("FAIL cg_off_next_edge: got %b expected 0", gclk); end
        #1 clk_en = 1'b1;
        #2;
        checks++; if (gclk !== 1'b0) begin failures++; $display("FAIL cg_no_glitch: got %b expected 0", gclk); end
        tick();
        checks++; if (gclk !== 1'b1) begin failures++; $display("FAIL cg_on_next_edge: got %b expected 1", gclk); end
        en_cur = 1'b1;
        rises0 = gclk_rises;
        exp_rises = 0;
        for (int i = 0; i < 30; i++) begin
            #1 clk_en = 1'($urandom_range(0, 1));
            #2;
            checks++; if (gclk !== en_cur) begin failures++; $display("FAIL cg_rand_high[%0d]: got %b expected %b", i, gclk, en_cur); end
            @(negedge clk2); #2 clk_en = 1'($urandom_range(0, 1));
            tick();
            en_cur = clk_en;
            exp_rises += int'(en_cur);
            checks++; if (gclk !== en_cur) begin failures++; $display("FAIL cg_rand_rise[%0d]: got %b expected %b", i, gclk, en_cur); end
        end
        checks++; if (gclk_rises - rises0 != exp_rises) begin failures++; $display("FAIL cg_rise_count: got %0d expected %0d", gclk_rises - rises0, exp_rises); end
        clk_en = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_vend();
        payment_method = 1'b0;
        set_price(1, 200);
        state = S_PAY;
        coins(0, 1, 1, 0); cancelled = 1'b1; tick();
        coins(0, 0, 0, 0); cancelled = 1'b0; state = S_SELECT; tick();
        set_price(6, 0);
        state = S_PAY; tick(); tick();
        checks++; if (change_state !== 1'b1) begin failures++; $display("FAIL rst_pre_change_state: got %b expected 1", change_state); end
        state = S_VEND; tick();
        checks++; if (reduce_inventory !== 1'b1 || change !== 9'd35) begin failures++; $display("FAIL rst_pre_vend: got ri=%b change=%0d expected ri=1 change=35", reduce_inventory, change); end
        rst = 1'b1;
        tick();
        checks++; if ({reduce_inventory, change_state, cancelled_done} !== 3'b000) begin failures++; $display("FAIL rst_mid_flags: got %b%b%b expected 000", reduce_inventory, change_state, cancelled_done); end
        checks++; if (change !== 9'd0) begin failures++; $display("FAIL rst_mid_change: got %0d expected 0", change); end
        checks++; if ({quarter_o, dime_o, nickel_o} !== 15'd0) begin failures++; $display("FAIL rst_mid_coins: got %0d/%0d/%0d expected 0/0/0", quarter_o, dime_o, nickel_o); end
        checks++; if (gclk !== 1'b1) begin failures++; $display("FAIL rst_gclk_on: got %b expected 1", gclk); end
        @(negedge clk2); #2 clk_en = 1'b0;
        tick();
        checks++; if (gclk !== 1'b0) begin failures++; $display("FAIL rst_gclk_follow: got %b expected 0", gclk); end
        clk_en = 1'b1;
        state = S_SELECT;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; state = S_SELECT; cancelled = 1'b0; payment_method = 1'b0;
        cost = '0; cur_index = '0; cred_balance = '0;
        coins(0, 0, 0, 0);
        reduce_inventory_done = 1'b0; change_state_done = 1'b0;
        test_reset();
        test_cash_exact();
        test_overpay();
        test_cancel();
        test_credit();
        test_saturation();
        test_random();
        test_clock_gate();
        test_reset_mid_vend();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at 1 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
